// File: rtl/br_table_resolver_if.sv
// Handshake and code-ROM bus for br_table_resolver.
// Each signal is named from the resolver's side: i_* flow into it and o_* flow out of it.
interface br_table_resolver_if #(
  parameter int MEM_DEPTH = 6,
  parameter int MEM_EXTRA = 4,
  parameter int LABEL_W   = 32
);
  logic                          i_start;
  logic [MEM_DEPTH:0]            i_pc;
  logic [LABEL_W-1:0]            i_index;
  logic [MEM_DEPTH:0]            o_mem_addr;
  logic [MEM_EXTRA-1:0]          o_mem_extra;
  logic [(2**MEM_EXTRA)*8-1:0]   i_mem_data;
  logic                          i_mem_error;
  logic                          o_busy;
  logic                          o_done;
  logic [LABEL_W-1:0]            o_label;
  logic [1:0]                    o_err;

  // resolver side
  modport slave (
    input  i_start, i_pc, i_index, i_mem_data, i_mem_error,
    output o_mem_addr, o_mem_extra, o_busy, o_done, o_label, o_err
  );

  // cpu decoder / code ROM side
  modport master (
    output i_start, i_pc, i_index, i_mem_data, i_mem_error,
    input  o_mem_addr, o_mem_extra, o_busy, o_done, o_label, o_err
  );
endinterface

// File: rtl/br_table_resolver.sv
// br_table operand resolver. It streams one code byte per cycle, decodes the
// LEB128 entry count, then skips the entries that come before the selected one,
// and finally returns that entry's label depth.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; label/err hold the last result
// S_COUNT  | decoding the vector length n
// S_SKIP   | consuming entries ahead of the selected one
// S_TARGET | decoding the selected (or default) entry
// S_FAULT  | one cycle after a fault, err valid, then back to idle
module br_table_resolver #(
  parameter int MEM_DEPTH = 6,
  parameter int MEM_EXTRA = 4,
  parameter int LABEL_W   = 32,
  parameter int MAX_LEB   = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  br_table_resolver_if.slave bus
);
  localparam int POS_W  = $clog2(MAX_LEB + 1);
  localparam int SH_W   = $clog2(7 * MAX_LEB + 1);
  localparam int DATA_W = (2**MEM_EXTRA) * 8;

  localparam logic [MEM_DEPTH:0] ADDR_ONE  = {{MEM_DEPTH{1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]   POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(MAX_LEB - 1);
  localparam logic [LABEL_W-1:0] LABEL_ONE = {{(LABEL_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_SKIP   = 3'd2,
    S_TARGET = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t             r_state;
  logic [MEM_DEPTH:0] r_mem_addr;
  logic               r_busy;
  logic               r_done;
  logic [LABEL_W-1:0] r_label;
  logic [1:0]         r_err;
  logic [LABEL_W-1:0] r_index;
  logic [LABEL_W-1:0] r_acc;
  logic [POS_W-1:0]   r_pos;
  logic [LABEL_W-1:0] r_remain;

  logic [7:0]         w_byte;
  logic               w_cont;
  logic [SH_W-1:0]    w_shamt;
  logic [LABEL_W+6:0] w_chunk;
  logic [LABEL_W-1:0] w_value;
  logic               w_bad_leb;
  logic               w_addr_last;
  logic               w_finish;
  logic [LABEL_W-1:0] w_sel;
  logic [1:0]         w_fault_code;
  logic               w_unused_data;

  assign w_byte        = bus.i_mem_data[7:0];
  assign w_unused_data = ^bus.i_mem_data[DATA_W-1:8];
  assign w_cont        = w_byte[7];
  assign w_shamt       = SH_W'(r_pos) * SH_W'(7);
  assign w_chunk       = {{LABEL_W{1'b0}}, w_byte[6:0]} << w_shamt;
  // r_pos == 0 marks the first byte of a value, so the stale accumulator is dropped
  assign w_value       = ((r_pos == '0) ? '0 : r_acc) | w_chunk[LABEL_W-1:0];
  assign w_bad_leb     = (|w_chunk[LABEL_W+6:LABEL_W]) || (w_cont && (r_pos == POS_LAST));
  assign w_addr_last   = &r_mem_addr;
  // only the terminating byte of the target entry may sit at the top address
  assign w_finish      = (r_state == S_TARGET) && !w_cont;
  assign w_sel         = (r_index < w_value) ? r_index : w_value;

  // Fault classification of the byte being consumed; mem_error dominates
  always_comb begin
    w_fault_code = 2'd0;
    if (bus.i_mem_error)
      w_fault_code = 2'd1;
    else if (w_bad_leb)
      w_fault_code = 2'd2;
    else if (w_addr_last && !w_finish)
      w_fault_code = 2'd3;
  end

  // Sequencer: byte streaming, LEB128 accumulation, entry skipping, result registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_label    <= '0;
      r_err      <= 2'd0;
      r_index    <= '0;
      r_acc      <= '0;
      r_pos      <= '0;
      r_remain   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_index    <= bus.i_index;
            r_mem_addr <= bus.i_pc;
            r_err      <= 2'd0;
            r_busy     <= 1'b1;
            r_pos      <= '0;
            r_acc      <= '0;
            r_state    <= S_COUNT;
          end
        end
        S_COUNT, S_SKIP, S_TARGET: begin
          r_mem_addr <= r_mem_addr + ADDR_ONE;
          r_acc      <= w_value;
          r_pos      <= w_cont ? (r_pos + POS_ONE) : '0;
          if (w_fault_code != 2'd0) begin
            r_err   <= w_fault_code;
            r_busy  <= 1'b0;
            r_state <= S_FAULT;
          end else if (!w_cont) begin
            case (r_state)
              S_COUNT: begin
                r_remain <= w_sel;
                r_state  <= (w_sel != '0) ? S_SKIP : S_TARGET;
              end
              S_SKIP: begin
                r_remain <= r_remain - LABEL_ONE;
                if (r_remain == LABEL_ONE)
                  r_state <= S_TARGET;
              end
              default: begin
                r_label <= w_value;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            endcase
          end
        end
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_extra = '0;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_label     = r_label;
  assign bus.o_err       = r_err;
endmodule

// File: tb/tb_br_table_resolver.sv
// Scoreboard bench for br_table_resolver. It uses a byte-array code ROM,
// directed scenarios and randomized vectors, and a value-level LEB128 reference model.
module tb_br_table_resolver;
  localparam int MAX_LEB = 5;

  typedef struct {
    bit          is_done;
    logic [31:0] label;
    logic [1:0]  err;
    int          nb;
    longint      due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rst_seen = 1'b1;
  longint     cyc = 0;
  logic [7:0] rom [128];
  int         bound = 128;
  exp_t       q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         prev_busy = 1'b0;

  br_table_resolver_if #(.MEM_DEPTH(6), .MEM_EXTRA(4), .LABEL_W(32)) bus ();

  br_table_resolver #(.MEM_DEPTH(6), .MEM_EXTRA(4), .LABEL_W(32), .MAX_LEB(MAX_LEB)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  assign bus.i_mem_data  = {{15{8'hA5}}, rom[bus.o_mem_addr]};
  assign bus.i_mem_error = (int'(bus.o_mem_addr) >= bound);

  // 100 MHz clock
  always #5 clk = ~clk;

  // cycle counter and the reset level the DUT actually sampled
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic exp_t mk(input bit d, input logic [31:0] l, input logic [1:0] e, input int nb);
    exp_t r;
    r.is_done = d; r.label = l; r.err = e; r.nb = nb; r.due = 0;
    return r;
  endfunction

  // One LEB128 value starting at address a; code: 0 ok, 1 mem error, 2 bad LEB, 3 wrap
  function automatic void read_value(input int a, input bit last, output longint unsigned val,
                                     output int nb, output int code);
    val = 0; nb = 0; code = 0;
    for (int i = 0; i < MAX_LEB; i++) begin
      logic [7:0] b;
      b  = rom[a + i];
      nb = i + 1;
      if (a + i >= bound) begin code = 1; return; end
      val = val | (longint'(b[6:0]) << (7 * i));
      if ((b[7] && i == MAX_LEB - 1) || val >= 64'h1_0000_0000) begin code = 2; return; end
      if (a + i == 127) begin
        if (b[7] || !last) code = 3;
        return;
      end
      if (!b[7]) return;
    end
  endfunction

  function automatic exp_t model(input int pc, input logic [31:0] idx);
    exp_t e;
    longint unsigned v, sel;
    int a, nb, code;
    e = mk(1'b0, 32'd0, 2'd0, 0);
    a = pc;
    read_value(a, 1'b0, v, nb, code);
    a += nb; e.nb += nb;
    if (code != 0) begin e.err = 2'(code); return e; end
    sel = (longint'(idx) < v) ? longint'(idx) : v;
    for (longint unsigned k = 0; k < sel; k++) begin
      read_value(a, 1'b0, v, nb, code);
      a += nb; e.nb += nb;
      if (code != 0) begin e.err = 2'(code); return e; end
    end
    read_value(a, 1'b1, v, nb, code);
    e.nb += nb;
    if (code != 0) begin e.err = 2'(code); return e; end
    e.is_done = 1'b1;
    e.label   = v[31:0];
    return e;
  endfunction

  task automatic load_rom(input int base, input logic [63:0] val, input int len);
    for (int i = 0; i < len; i++) rom[base + i] = val[8*(len-1-i) +: 8];
  endtask

  // call at a negedge: request is sampled at the next posedge
  task automatic issue(input int pc, input logic [31:0] idx, input exp_t e);
    bus.i_start = 1'b1;
    bus.i_pc    = 7'(pc);
    bus.i_index = idx;
    e.due       = cyc + 1 + e.nb;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && q.size() != 0; i++) @(negedge clk);
    check("drained", q.size(), 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int pc, input logic [31:0] idx, input exp_t e);
    @(negedge clk);
    issue(pc, idx, e);
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();
  endtask

  // Monitor: every busy falling edge is a completion, matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !bus.o_busy) begin
        check("queue_nonempty_at_end", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("done", bus.o_done, e.is_done);
          check("err", bus.o_err, e.err);
          if (e.is_done) check("label", bus.o_label, e.label);
          check("latency", cyc, e.due);
        end
      end else begin
        check("done_only_at_end", bus.o_done, 0);
      end
      prev_busy = bus.o_busy;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pc;
    logic [31:0] idx;
    foreach (rom[i]) rom[i] = 8'h00;
    bus.i_start = 1'b0;
    bus.i_pc    = '0;
    bus.i_index = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", bus.o_mem_addr, 0);
    check("rst_extra", bus.o_mem_extra, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_label", bus.o_label, 0);
    check("rst_err", bus.o_err, 0);
    reset = 1'b0;

    load_rom(0, 64'h03_00_01_02_05, 5);
    run(0, 32'd1, mk(1'b1, 32'd1, 2'd0, 3));
    // default entry, with an extra start while busy that must be ignored
    @(negedge clk);
    issue(0, 32'd7, mk(1'b1, 32'd5, 2'd0, 5));
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_pc = 7'd3; bus.i_index = 32'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();

    // multi-byte skip, then a start issued in the done cycle
    load_rom(0, 64'h02_80_01_05_2A, 5);
    @(negedge clk);
    issue(0, 32'd1, mk(1'b1, 32'd5, 2'd0, 4));
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 50 && !bus.o_done; i++) @(negedge clk);
    issue(0, 32'd0, mk(1'b1, 32'd128, 2'd0, 3));
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();

    load_rom(0, 64'h01_FF_FF_FF_FF_FF_01, 7);
    run(0, 32'd0, mk(1'b0, 32'd0, 2'd2, 6));

    load_rom(0, 64'h03_00_01_02, 4);
    bound = 2;
    run(0, 32'd2, mk(1'b0, 32'd0, 2'd1, 3));
    bound = 128;

    // n = 0 and index == n both select the default; full-width unsigned index
    load_rom(0, 64'h00_07, 2);
    run(0, 32'd5, mk(1'b1, 32'd7, 2'd0, 2));
    load_rom(0, 64'h02_0A_0B_0C, 4);
    run(0, 32'd2, mk(1'b1, 32'h0C, 2'd0, 4));
    run(0, 32'd1, mk(1'b1, 32'h0B, 2'd0, 3));
    run(0, 32'hFFFF_FFFF, mk(1'b1, 32'h0C, 2'd0, 4));

    // top address: wrap alone, then mem_error outranking wrap
    rom[127] = 8'h02;
    run(127, 32'd0, mk(1'b0, 32'd0, 2'd3, 1));
    bound = 127;
    run(127, 32'd0, mk(1'b0, 32'd0, 2'd1, 1));
    bound = 128;

    // reset while skipping aborts silently
    load_rom(0, 64'h03_00_01_02_05, 5);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_pc = 7'd0; bus.i_index = 32'd7;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_addr", bus.o_mem_addr, 0);
    check("abort_busy", bus.o_busy, 0);
    check("abort_done", bus.o_done, 0);
    check("abort_label", bus.o_label, 0);
    check("abort_err", bus.o_err, 0);
    reset = 1'b0;
    run(0, 32'd1, mk(1'b1, 32'd1, 2'd0, 3));

    for (int t = 0; t < 40; t++) begin
      foreach (rom[i])
        rom[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 6));
      bound = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : 128;
      pc    = int'($urandom_range(0, 127));
      idx   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 6)) : 32'($urandom);
      run(pc, idx, model(pc, idx));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
